adc_frame_sequencer: RTL and testbench

//  Synchronous sequencer for the 4-channel hydrophone ADC serial capture path. Runs on master_clk.
//  On each DRDY falling edge it generates SCLK, shifts 24 bits from each of 4 MISO lines
//  (pf, pa, sf, sa), then packs one 128-bit frame with sequence/status into the capture FIFO.

---
 rtl/adc_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_adc_frame_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer
// Captures one conversion from the 4-channel hydrophone ADC per DRDY falling
// edge: generates SCLK, shifts SAMPLE_BITS bits from each MISO line and packs
// {flags, seq, pf, pa, sf, sa} into one 128-bit word for the capture FIFO.
// Dropped frames (FIFO full) and DRDY edges missed while busy are flagged in
// the next written frame and counted in a saturating overrun counter.
module adc_frame_sequencer #(
   parameter int SAMPLE_BITS = 24,
   parameter int SCLK_DIV    = 2,
   parameter int SEQ_W       = 24
) (
   input  logic         master_clk,
   input  logic         global_reset_n,
   input  logic         enable,
   input  logic         drdy_in,
   input  logic [3:0]   miso_in,
   output logic         sclk_out,
   input  logic         fifo_full,
   output logic         fifo_wrreq,
   output logic [127:0] fifo_data,
   output logic         busy,
   output logic [15:0]  overrun_cnt
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SHIFT,
      PUSH
   } state_t;

   state_t state;
   state_t state_nxt;

   // DRDY synchroniser and edge detect
   logic drdy_s1;
   logic drdy_s2;
   logic drdy_prev;
   logic fall_evt;

   // serial capture datapath
   logic [DIV_W-1:0]       div_cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic [SAMPLE_BITS-1:0] sr_pf;
   logic [SAMPLE_BITS-1:0] sr_pa;
   logic [SAMPLE_BITS-1:0] sr_sf;
   logic [SAMPLE_BITS-1:0] sr_sa;

   // frame status
   logic [SEQ_W-1:0] seq;
   logic [1:0]       flags;
   logic [127:0]     data_hold;
   logic [127:0]     frame_word;
   logic [16:0]      ovr_sum;

   // decoded events
   logic div_tc;
   logic sclk_fall;
   logic last_bit;
   logic shift_start;
   logic miss_evt;
   logic drop_evt;
   logic write_evt;

   assign fall_evt    = drdy_prev & ~drdy_s2;
   assign div_tc      = (div_cnt == DIV_W'(SCLK_DIV - 1));
   assign sclk_fall   = (state == SHIFT) && div_tc && sclk_out;
   assign last_bit    = (bit_cnt == BIT_W'(SAMPLE_BITS - 1));
   assign shift_start = (state == WAIT) && (state_nxt == SHIFT);
   assign miss_evt    = fall_evt && ((state == SHIFT) || (state == PUSH));
   assign drop_evt    = (state == PUSH) && fifo_full;
   assign write_evt   = (state == PUSH) && !fifo_full;

   assign frame_word  = {6'b0, flags, seq, sr_pf, sr_pa, sr_sf, sr_sa};
   assign ovr_sum     = {1'b0, overrun_cnt} + {16'd0, drop_evt} + {16'd0, miss_evt};

   assign fifo_wrreq  = write_evt;
   assign fifo_data   = write_evt ? frame_word : data_hold;
   assign busy        = (state == SHIFT) || (state == PUSH);

   // Synchronise DRDY into master_clk and keep one previous sample for edge detect
   always_ff @(posedge master_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         drdy_s1   <= 1'b1;
         drdy_s2   <= 1'b1;
         drdy_prev <= 1'b1;
      end else begin
         drdy_s1   <= drdy_in;
         drdy_s2   <= drdy_s1;
         drdy_prev <= drdy_s2;
      end
   end

   // Sequencer state register
   always_ff @(posedge master_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; SHIFT ignores enable so a frame is never truncated
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (fall_evt) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (sclk_fall && last_bit) begin
               state_nxt = PUSH;
            end
         end
         PUSH: begin
            state_nxt = enable ? WAIT : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // SCLK divider and MSB-first shift of all four channels on each SCLK fall
   always_ff @(posedge master_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sclk_out <= 1'b0;
         sr_pf    <= '0;
         sr_pa    <= '0;
         sr_sf    <= '0;
         sr_sa    <= '0;
      end else if (shift_start) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sclk_out <= 1'b0;
         sr_pf    <= '0;
         sr_pa    <= '0;
         sr_sf    <= '0;
         sr_sa    <= '0;
      end else if (state == SHIFT) begin
         if (div_tc) begin
            div_cnt  <= '0;
            sclk_out <= ~sclk_out;
            if (sclk_out) begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               sr_pf   <= {sr_pf[SAMPLE_BITS-2:0], miso_in[3]};
               sr_pa   <= {sr_pa[SAMPLE_BITS-2:0], miso_in[2]};
               sr_sf   <= {sr_sf[SAMPLE_BITS-2:0], miso_in[1]};
               sr_sa   <= {sr_sa[SAMPLE_BITS-2:0], miso_in[0]};
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end else begin
         sclk_out <= 1'b0;
      end
   end

   // Frame sequence, sticky flags, held output word and saturating overrun count
   always_ff @(posedge master_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         seq         <= '0;
         flags       <= '0;
         data_hold   <= '0;
         overrun_cnt <= '0;
      end else begin
         if (state == PUSH) begin
            seq <= seq + SEQ_W'(1);
         end
         // a miss landing in the same cycle as a write is not in that word,
         // so it stays flagged for the following frame
         if (write_evt) begin
            data_hold <= frame_word;
            flags     <= {miss_evt, 1'b0};
         end else begin
            if (drop_evt) begin
               flags[0] <= 1'b1;
            end
            if (miss_evt) begin
               flags[1] <= 1'b1;
            end
         end
         overrun_cnt <= ovr_sum[16] ? '1 : ovr_sum[15:0];
      end
   end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer
// Directed bench for adc_frame_sequencer with SCLK_DIV=2, SAMPLE_BITS=24.
// A negedge process models the ADC (new MISO bit on each SCLK rise) and logs
// every FIFO write; the main thread runs the capture scenarios.
module tb_adc_frame_sequencer;

   logic         master_clk = 1'b0;
   logic         global_reset_n;
   logic         enable;
   logic         drdy_in;
   logic [3:0]   miso_in = '0;
   logic         sclk_out;
   logic         fifo_full;
   logic         fifo_wrreq;
   logic [127:0] fifo_data;
   logic         busy;
   logic [15:0]  overrun_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [23:0] pat_pf;
   logic [23:0] pat_pa;
   logic [23:0] pat_sf;
   logic [23:0] pat_sa;

   int unsigned  cyc           = 0;
   int unsigned  rise_total    = 0;
   int unsigned  rise_period   = 0;
   int unsigned  last_rise_cyc = 0;
   int unsigned  bit_idx       = 0;
   logic         sclk_prev     = 1'b0;
   logic [127:0] wr_log[$];
   int unsigned  wr_cyc[$];

   adc_frame_sequencer #(
      .SAMPLE_BITS (24),
      .SCLK_DIV    (2),
      .SEQ_W       (24)
   ) dut (
      .master_clk     (master_clk),
      .global_reset_n (global_reset_n),
      .enable         (enable),
      .drdy_in        (drdy_in),
      .miso_in        (miso_in),
      .sclk_out       (sclk_out),
      .fifo_full      (fifo_full),
      .fifo_wrreq     (fifo_wrreq),
      .fifo_data      (fifo_data),
      .busy           (busy),
      .overrun_cnt    (overrun_cnt)
   );

   always #5 master_clk = ~master_clk;

   // ADC model and write logger, sampled on the inactive clock edge
   always @(negedge master_clk) begin
      cyc++;
      if (fifo_wrreq) begin
         wr_log.push_back(fifo_data);
         wr_cyc.push_back(cyc);
      end
      if (sclk_out && !sclk_prev) begin
         rise_period   = cyc - last_rise_cyc;
         last_rise_cyc = cyc;
         rise_total++;
      end
      if (!busy) begin
         bit_idx = 0;
      end else if (sclk_out && !sclk_prev) begin
         if (bit_idx < 24) begin
            miso_in = {pat_pf[23-bit_idx], pat_pa[23-bit_idx],
                       pat_sf[23-bit_idx], pat_sa[23-bit_idx]};
         end
         bit_idx++;
      end
      sclk_prev = sclk_out;
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int unsigned idx, input logic [127:0] exp);
      logic [127:0] v;
      v = (idx < wr_log.size()) ? wr_log[idx] : 'x;
      check_eq(tag, v, exp);
   endtask

   task automatic tick();
      @(posedge master_clk);
      #2;
   endtask

   task automatic drdy_pulse();
      drdy_in = 1'b0;
      repeat (4) tick();
      drdy_in = 1'b1;
   endtask

   task automatic set_pat(input logic [23:0] pf, input logic [23:0] pa,
                          input logic [23:0] sf, input logic [23:0] sa);
      pat_pf = pf;
      pat_pa = pa;
      pat_sf = sf;
      pat_sa = sa;
   endtask

   int unsigned w0;
   int unsigned r0;
   int unsigned c0;

   initial begin
      global_reset_n = 1'b0;
      enable         = 1'b0;
      drdy_in        = 1'b1;
      fifo_full      = 1'b0;
      set_pat(24'h0, 24'h0, 24'h0, 24'h0);
      repeat (3) tick();

      check_eq("rst_sclk", sclk_out, 0);
      check_eq("rst_wrreq", fifo_wrreq, 0);
      check_eq("rst_data", fifo_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ovr", overrun_cnt, 0);

      global_reset_n = 1'b1;
      repeat (2) tick();
      enable = 1'b1;
      repeat (3) tick();

      // T1: constant 1010 on the MISO lines
      set_pat(24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000);
      w0 = wr_log.size();
      r0 = rise_total;
      c0 = cyc;
      drdy_pulse();
      repeat (110) tick();
      check_eq("t1_writes", wr_log.size() - w0, 1);
      check_eq("t1_rises", rise_total - r0, 24);
      check_eq("t1_period", rise_period, 4);
      check_eq("t1_latency", (w0 < wr_cyc.size()) ? wr_cyc[w0] - c0 : 0, 100);
      check_wr("t1_data", w0, 128'h00_000000_FFFFFF_000000_FFFFFF_000000);
      check_eq("t1_sclk_idle", sclk_out, 0);

      // T2: patterned channels, sequence advances
      set_pat(24'hABCDEF, 24'h123456, 24'h800001, 24'h7FFFFE);
      w0 = wr_log.size();
      drdy_pulse();
      repeat (110) tick();
      check_eq("t2_writes", wr_log.size() - w0, 1);
      check_wr("t2_data", w0, 128'h00_000001_ABCDEF_123456_800001_7FFFFE);
      check_eq("t2_hold", fifo_data, 128'h00_000001_ABCDEF_123456_800001_7FFFFE);

      // T3: FIFO full for the middle one of three frames
      set_pat(24'h000001, 24'h000002, 24'h000003, 24'h000004);
      w0 = wr_log.size();
      drdy_pulse();
      repeat (110) tick();
      fifo_full = 1'b1;
      drdy_pulse();
      repeat (110) tick();
      check_eq("t3_hold_on_drop", fifo_data, 128'h00_000002_000001_000002_000003_000004);
      fifo_full = 1'b0;
      drdy_pulse();
      repeat (110) tick();
      check_eq("t3_writes", wr_log.size() - w0, 2);
      check_wr("t3_first", w0, 128'h00_000002_000001_000002_000003_000004);
      check_wr("t3_after_drop", w0 + 1, 128'h01_000004_000001_000002_000003_000004);
      check_eq("t3_ovr", overrun_cnt, 1);

      // T4: second DRDY fall arrives early in SHIFT
      set_pat(24'h5A5A5A, 24'hA5A5A5, 24'hC3C3C3, 24'h3C3C3C);
      w0 = wr_log.size();
      r0 = rise_total;
      drdy_pulse();
      repeat (6) tick();
      drdy_pulse();
      repeat (100) tick();
      check_eq("t4_writes", wr_log.size() - w0, 1);
      check_eq("t4_rises", rise_total - r0, 24);
      check_wr("t4_miss_flag", w0, 128'h02_000005_5A5A5A_A5A5A5_C3C3C3_3C3C3C);
      check_eq("t4_ovr", overrun_cnt, 2);
      drdy_pulse();
      repeat (110) tick();
      check_wr("t4_flags_clear", w0 + 1, 128'h00_000006_5A5A5A_A5A5A5_C3C3C3_3C3C3C);

      // T5: enable drops at bit 5, frame still completes
      w0 = wr_log.size();
      drdy_pulse();
      repeat (19) tick();
      enable = 1'b0;
      repeat (100) tick();
      check_eq("t5_writes", wr_log.size() - w0, 1);
      check_wr("t5_data", w0, 128'h00_000007_5A5A5A_A5A5A5_C3C3C3_3C3C3C);
      check_eq("t5_busy", busy, 0);
      w0 = wr_log.size();
      r0 = rise_total;
      drdy_pulse();
      repeat (110) tick();
      check_eq("t5_idle_rises", rise_total - r0, 0);
      check_eq("t5_idle_writes", wr_log.size() - w0, 0);
      check_eq("t5_idle_ovr", overrun_cnt, 2);

      // T6: reset in the middle of a frame
      enable = 1'b1;
      repeat (3) tick();
      set_pat(24'hABCDEF, 24'h123456, 24'h800001, 24'h7FFFFE);
      w0 = wr_log.size();
      drdy_pulse();
      repeat (45) tick();
      check_eq("t6_sclk_pre", sclk_out, 1);
      global_reset_n = 1'b0;
      #1;
      check_eq("t6_sclk_rst", sclk_out, 0);
      check_eq("t6_busy_rst", busy, 0);
      check_eq("t6_wrreq_rst", fifo_wrreq, 0);
      repeat (3) tick();
      check_eq("t6_data_rst", fifo_data, 0);
      check_eq("t6_ovr_rst", overrun_cnt, 0);
      global_reset_n = 1'b1;
      repeat (3) tick();
      check_eq("t6_no_partial", wr_log.size() - w0, 0);
      drdy_pulse();
      repeat (110) tick();
      check_eq("t6_writes", wr_log.size() - w0, 1);
      check_wr("t6_seq_restart", w0, 128'h00_000000_ABCDEF_123456_800001_7FFFFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
